// File: rtl/wb_daq_sram_writer.sv
// Captures DAQ sample words into a small FIFO and drains them as single-word
// Wishbone classic writes into a circular buffer in system memory.
//
// state | meaning
// IDLE  | no bus cycle; start one when enabled, length!=0, FIFO has data, no error
// BUS   | cyc/stb/we asserted, waiting for ack, err or rty
// RETRY | one dead cycle after rty, then the same word is re-issued
// ERROR | halted after err until clear_status
module wb_daq_sram_writer #(
  parameter int dw      = 32,
  parameter int aw      = 32,
  parameter int fifo_aw = 2
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          enable,
  input  logic [aw-1:0] base_address,
  input  logic [15:0]   length,
  input  logic          clear_status,
  input  logic [dw-1:0] data_in,
  input  logic          data_valid,
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i,
  output logic          wrap,
  output logic          overflow,
  output logic          error,
  output logic [15:0]   word_offset
);

  typedef enum logic [1:0] {IDLE, BUS, RETRY, ERROR} state_t;

  localparam int depth = 1 << fifo_aw;
  localparam logic [fifo_aw:0] ptr_one = 1;

  state_t              state_q, state_d;
  logic [fifo_aw:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [dw-1:0]       mem_q [depth];
  logic [aw-1:0]       adr_q, adr_d;
  logic [dw-1:0]       dat_q, dat_d;
  logic [15:0]         offset_q, offset_d;
  logic                bus_q, bus_d;
  logic                wrap_q, wrap_d;
  logic                overflow_q, overflow_d;
  logic                error_q, error_d;
  logic                fifo_empty, fifo_full, fifo_wr;
  logic [aw-1:0]       base_clean;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[fifo_aw] != rd_ptr_q[fifo_aw]) &&
                      (wr_ptr_q[fifo_aw-1:0] == rd_ptr_q[fifo_aw-1:0]);
  assign fifo_wr    = data_valid && !fifo_full;
  assign base_clean = base_address & ~aw'(3);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = fifo_wr ? wr_ptr_q + ptr_one : wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    offset_d   = offset_q;
    wrap_d     = 1'b0;
    overflow_d = overflow_q;
    error_d    = error_q;

    // clear first so a coincident set wins
    if (clear_status) begin
      overflow_d = 1'b0;
      error_d    = 1'b0;
    end
    if (data_valid && fifo_full) overflow_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (!enable) begin
          offset_d = '0;
        end else if (length != 16'd0 && !fifo_empty && !error_q) begin
          state_d = BUS;
          adr_d   = base_clean + aw'({offset_q, 2'b00});
          dat_d   = mem_q[rd_ptr_q[fifo_aw-1:0]];
        end
      end
      BUS: begin
        if (wb_err_i) begin
          state_d = ERROR;
          error_d = 1'b1;
        end else if (wb_rty_i) begin
          state_d = RETRY;
        end else if (wb_ack_i) begin
          state_d  = IDLE;
          rd_ptr_d = rd_ptr_q + ptr_one;
          if (offset_q == length - 16'd1) begin
            offset_d = '0;
            wrap_d   = 1'b1;
          end else begin
            offset_d = offset_q + 16'd1;
          end
        end
      end
      RETRY:   state_d = BUS;
      ERROR:   if (clear_status) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    bus_d = (state_d == BUS);
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      offset_q   <= '0;
      bus_q      <= 1'b0;
      wrap_q     <= 1'b0;
      overflow_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      offset_q   <= offset_d;
      bus_q      <= bus_d;
      wrap_q     <= wrap_d;
      overflow_q <= overflow_d;
      error_q    <= error_d;
    end
  end

  // storage needs no reset; the pointers define what is valid
  always_ff @(posedge wb_clk) begin
    if (fifo_wr) mem_q[wr_ptr_q[fifo_aw-1:0]] <= data_in;
  end

  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = {4{bus_q}};
  assign wb_we_o     = bus_q;
  assign wb_cyc_o    = bus_q;
  assign wb_stb_o    = bus_q;
  assign wb_cti_o    = 3'b000;
  assign wb_bte_o    = 2'b00;
  assign wrap        = wrap_q;
  assign overflow    = overflow_q;
  assign error       = error_q;
  assign word_offset = offset_q;

endmodule

// File: tb/tb_wb_daq_sram_writer.sv
// Scoreboard bench for wb_daq_sram_writer: a Wishbone slave model pops expected
// words at each ack and checks address/data against an independent offset model.
module tb_wb_daq_sram_writer;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          wb_clk = 1'b0;
  logic          wb_rst = 1'b1;
  logic          enable = 1'b0;
  logic [AW-1:0] base_address = 32'h1000;
  logic [15:0]   length = 16'd4;
  logic          clear_status = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          data_valid = 1'b0;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic          wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0]    wb_cti_o;
  logic [1:0]    wb_bte_o;
  logic          wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;
  logic          wrap, overflow, error;
  logic [15:0]   word_offset;

  int vectors = 0;
  int miscompares = 0;

  wb_daq_sram_writer dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .enable(enable),
    .base_address(base_address), .length(length), .clear_status(clear_status),
    .data_in(data_in), .data_valid(data_valid),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .wrap(wrap), .overflow(overflow), .error(error), .word_offset(word_offset)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard and slave model state
  logic [DW-1:0] exp_q[$];
  bit            ack_en = 1'b0, rty_next = 1'b0, err_next = 1'b0, rty_chk = 1'b0;
  logic [AW-1:0] rty_adr;
  logic [DW-1:0] rty_dat;
  int            exp_off = 0;
  int            exp_wraps = 0;
  int            wraps_seen = 0;
  int            low_run = 0;
  bit            had_cyc = 1'b0;
  int            gaps[$];

  always @(negedge wb_clk) begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_rty_i = 1'b0;
    if (wb_cyc_o && wb_stb_o && !wb_rst) begin
      if (rty_chk) begin
        check("retry_adr", wb_adr_o, rty_adr);
        check("retry_dat", wb_dat_o, rty_dat);
        rty_chk = 1'b0;
      end
      if (err_next) begin
        wb_err_i = 1'b1;
        err_next = 1'b0;
      end else if (rty_next) begin
        wb_rty_i = 1'b1;
        rty_next = 1'b0;
        rty_chk  = 1'b1;
        rty_adr  = wb_adr_o;
        rty_dat  = wb_dat_o;
      end else if (ack_en) begin
        wb_ack_i = 1'b1;
        check("wr_sel", wb_sel_o, 4'hF);
        check("wr_we", wb_we_o, 1'b1);
        check("wr_adr", wb_adr_o, base_address + 32'(exp_off * 4));
        if (exp_q.size() == 0) check("wr_extra_word", exp_q.size(), 1);
        else check("wr_dat", wb_dat_o, exp_q.pop_front());
        if (exp_off == int'(length) - 1) begin
          exp_off = 0;
          exp_wraps++;
        end else begin
          exp_off++;
        end
      end
    end
  end

  always @(negedge wb_clk) begin
    if (wrap) wraps_seen++;
    if (!wb_cyc_o) begin
      low_run++;
    end else begin
      if (had_cyc && low_run > 0) gaps.push_back(low_run);
      low_run = 0;
      had_cyc = 1'b1;
    end
  end

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    data_in    = d;
    data_valid = 1'b1;
    if (exp_q.size() < 4) exp_q.push_back(d);
    tick();
    data_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || wb_cyc_o) && n < 60) begin
      tick();
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic wait_cyc(input logic lvl, input string tag);
    int n = 0;
    while (wb_cyc_o !== lvl && n < 20) begin
      tick();
      n++;
    end
    check(tag, wb_cyc_o, lvl);
  endtask

  task automatic no_cycles(input int n, input string tag);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (wb_cyc_o) seen++;
    end
    check(tag, seen, 0);
  endtask

  task automatic restart_offset();
    enable = 1'b0;
    tick();
    exp_off = 0;
    enable  = 1'b1;
  endtask

  task automatic clear_gaps();
    gaps.delete();
    had_cyc = 1'b0;
    low_run = 0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cyc"}, wb_cyc_o, 1'b0);
    check({pfx, "_stb"}, wb_stb_o, 1'b0);
    check({pfx, "_we"}, wb_we_o, 1'b0);
    check({pfx, "_sel"}, wb_sel_o, 4'h0);
    check({pfx, "_adr"}, wb_adr_o, 32'h0);
    check({pfx, "_dat"}, wb_dat_o, 32'h0);
    check({pfx, "_cti_bte"}, {wb_cti_o, wb_bte_o}, 5'b0);
    check({pfx, "_wrap"}, wrap, 1'b0);
    check({pfx, "_overflow"}, overflow, 1'b0);
    check({pfx, "_error"}, error, 1'b0);
    check({pfx, "_offset"}, word_offset, 16'd0);
  endtask

  initial begin
    tick();
    tick();
    check_reset_outputs("reset");
    wb_rst = 1'b0;
    tick();

    // basic: three words, first-word latency, one idle cycle between writes
    base_address = 32'h1000;
    length = 16'd4;
    enable = 1'b1;
    ack_en = 1'b1;
    clear_gaps();
    push(32'hA0);
    check("latency_edge_n", wb_cyc_o, 1'b0);
    push(32'hA1);
    check("latency_edge_n1", wb_cyc_o, 1'b1);
    push(32'hA2);
    drain("basic_drain");
    check("basic_gap_count", gaps.size(), 2);
    foreach (gaps[i]) check("basic_gap_len", gaps[i], 1);
    check("basic_offset", word_offset, 16'(exp_off));
    check("basic_no_wrap", wraps_seen, 0);

    // wrap with length 2
    restart_offset();
    length = 16'd2;
    push(32'hB0);
    push(32'hB1);
    push(32'hB2);
    drain("wrap_drain");
    check("wrap_offset", word_offset, 16'(exp_off));
    check("wrap_count", wraps_seen, exp_wraps);

    // overflow: ack withheld, six strobes into a depth-4 FIFO
    length = 16'd4;
    restart_offset();
    ack_en = 1'b0;
    for (int i = 0; i < 6; i++) push(32'hC0 + 32'(i));
    check("ovf_set", overflow, 1'b1);
    clear_status = 1'b1;
    push(32'hC6);
    clear_status = 1'b0;
    check("ovf_set_beats_clear", overflow, 1'b1);
    ack_en = 1'b1;
    drain("ovf_drain");
    check("ovf_sticky", overflow, 1'b1);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    check("ovf_cleared", overflow, 1'b0);

    // retry: one idle cycle, identical address and data re-issued
    restart_offset();
    clear_gaps();
    rty_next = 1'b1;
    push(32'hD0);
    drain("rty_drain");
    check("rty_gap_count", gaps.size(), 1);
    foreach (gaps[i]) check("rty_gap_len", gaps[i], 1);

    // error: halts with the word kept, clear_status rewrites it
    err_next = 1'b1;
    push(32'hE0);
    tick();
    tick();
    check("err_set", error, 1'b1);
    no_cycles(5, "err_no_cycle");
    check("err_sticky", error, 1'b1);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    check("err_cleared", error, 1'b0);
    drain("err_rewrite");

    // length 0 blocks transfers
    restart_offset();
    length = 16'd0;
    push(32'hF0);
    no_cycles(6, "len0_no_cycle");
    check("len0_offset", word_offset, 16'd0);

    // reset while a cycle is open
    length = 16'd4;
    ack_en = 1'b0;
    wait_cyc(1'b1, "rst_cyc_open");
    wb_rst = 1'b1;
    tick();
    check_reset_outputs("rst_mid");
    wb_rst = 1'b0;
    exp_q.delete();
    exp_off = 0;
    ack_en = 1'b1;
    no_cycles(5, "rst_fifo_empty");

    // enable dropped mid-cycle: finishes on ack, no further cycle, offset zeroed
    ack_en = 1'b0;
    push(32'h60);
    push(32'h61);
    wait_cyc(1'b1, "en_cyc_open");
    enable = 1'b0;
    ack_en = 1'b1;
    wait_cyc(1'b0, "en_cycle_done");
    no_cycles(5, "en_no_more");
    check("en_offset_zero", word_offset, 16'd0);
    exp_off = 0;
    enable = 1'b1;
    drain("en_resume");

    check("wrap_total", wraps_seen, exp_wraps);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
